// File: rtl/sha256_msg_if.sv
// Word stream from the message source into the SHA-256 message controller.
interface sha256_msg_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [1:0]  s_bytes;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_last, output s_bytes, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, input s_bytes, output s_ready);
endinterface

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: collects big-endian words into 512-bit blocks,
// applies padding/length, sequences an external transform and chains the result.
module sha256_msg_ctrl #(
  parameter int LOOP       = 1,
  parameter int TF_LATENCY = 68
) (
  input  logic           clk,
  input  logic           reset_n,
  sha256_msg_if.slave    s,
  output logic           tf_feedback,
  output logic [5:0]     tf_cnt,
  output logic [255:0]   tf_state,
  output logic [511:0]   tf_input,
  input  logic [255:0]   tf_hash,
  output logic [255:0]   digest,
  output logic           digest_valid,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, PAD = 3'd2, RUN = 3'd3, NEXT = 3'd4} state_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Keep the valid bytes of the last word and place the 0x80 marker right after them.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [1:0] nb);
    case (nb)
      2'd1:    pad_word = {d[31:24], 24'h800000};
      2'd2:    pad_word = {d[31:16], 16'h8000};
      2'd3:    pad_word = {d[31:8], 8'h80};
      default: pad_word = d;
    endcase
  endfunction

  function automatic logic [2:0] word_bytes(input logic last, input logic [1:0] nb);
    if (!last)           word_bytes = 3'd4;
    else if (nb == 2'd0) word_bytes = 3'd4;
    else                 word_bytes = {1'b0, nb};
  endfunction

  state_t              state_q, state_d;
  logic [15:0][31:0]   blk_q, blk_d;        // word 0 lives in blk_q[15]
  logic [3:0]          idx_q, idx_d;
  logic [60:0]         byte_cnt_q, byte_cnt_d;
  logic [255:0]        hstate_q, hstate_d;
  logic [255:0]        hash_q, hash_d;
  logic [255:0]        digest_q, digest_d;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic [5:0]          tf_cnt_q, tf_cnt_d;
  logic                fb_q, fb_d;
  logic                final_q, final_d;
  logic                pad2_q, pad2_d;
  logic                pad2_80_q, pad2_80_d;
  logic [3:0]          lastidx_q, lastidx_d;
  logic [1:0]          lastb_q, lastb_d;
  logic                dv_q, dv_d;
  logic                busy_q, busy_d;
  logic                s_ready_q, s_ready_d;
  logic                xfer_s;
  logic [63:0]         bitlen_s;
  logic [4:0]          pos80_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    hstate_d   = hstate_q;
    hash_d     = hash_q;
    digest_d   = digest_q;
    run_cnt_d  = run_cnt_q;
    tf_cnt_d   = 6'd0;
    final_d    = final_q;
    pad2_d     = pad2_q;
    pad2_80_d  = pad2_80_q;
    lastidx_d  = lastidx_q;
    lastb_d    = lastb_q;
    dv_d       = dv_q;
    busy_d     = busy_q;
    xfer_s     = s.s_valid && s_ready_q;
    bitlen_s   = {byte_cnt_q, 3'b000};
    pos80_s    = {1'b0, lastidx_q} + ((lastb_q == 2'd0) ? 5'd1 : 5'd0);

    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          blk_d[15]  = s.s_data;
          idx_d      = 4'd1;
          byte_cnt_d = 61'(word_bytes(s.s_last, s.s_bytes));
          hstate_d   = IV;
          dv_d       = 1'b0;
          busy_d     = 1'b1;
          pad2_d     = 1'b0;
          pad2_80_d  = 1'b0;
          lastidx_d  = 4'd0;
          lastb_d    = s.s_bytes;
          state_d    = s.s_last ? PAD : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (xfer_s) begin
          blk_d[4'd15 - idx_q] = s.s_data;
          byte_cnt_d = byte_cnt_q + 61'(word_bytes(s.s_last, s.s_bytes));
          if (s.s_last) begin
            lastidx_d = idx_q;
            lastb_d   = s.s_bytes;
            state_d   = PAD;
          end else if (idx_q == 4'd15) begin
            idx_d     = 4'd0;
            final_d   = 1'b0;
            run_cnt_d = 16'd0;
            state_d   = RUN;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      PAD: begin
        if (pad2_q) begin
          // Length-only trailer block; carries the marker if the data block was full.
          blk_d     = '0;
          blk_d[15] = pad2_80_q ? 32'h8000_0000 : 32'h0000_0000;
          blk_d[1]  = bitlen_s[63:32];
          blk_d[0]  = bitlen_s[31:0];
          final_d   = 1'b1;
          pad2_d    = 1'b0;
        end else begin
          for (int w = 0; w < 16; w++) begin
            if (w == int'(lastidx_q)) begin
              blk_d[4'(15 - w)] = pad_word(blk_q[4'(15 - w)], lastb_q);
            end else if (w > int'(lastidx_q)) begin
              blk_d[4'(15 - w)] = (5'(w) == pos80_s) ? 32'h8000_0000 : 32'h0000_0000;
            end else begin
              blk_d[4'(15 - w)] = blk_q[4'(15 - w)];
            end
          end
          if (pos80_s <= 5'd13) begin
            blk_d[1]  = bitlen_s[63:32];
            blk_d[0]  = bitlen_s[31:0];
            final_d   = 1'b1;
          end else begin
            final_d   = 1'b0;
            pad2_d    = 1'b1;
            pad2_80_d = (pos80_s == 5'd16);
          end
        end
        run_cnt_d = 16'd0;
        state_d   = RUN;
      end
      RUN: begin
        if (run_cnt_q == 16'(TF_LATENCY - 1)) begin
          hash_d  = tf_hash;
          state_d = NEXT;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
          tf_cnt_d  = (tf_cnt_q == 6'(LOOP - 1)) ? 6'd0 : tf_cnt_q + 6'd1;
        end
      end
      NEXT: begin
        if (final_q) begin
          digest_d = hash_q;
          dv_d     = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          hstate_d = hash_q;
          if (pad2_q) begin
            state_d = PAD;
          end else begin
            idx_d   = 4'd0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
    fb_d      = (tf_cnt_d != 6'd0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      idx_q      <= 4'd0;
      byte_cnt_q <= 61'd0;
      hstate_q   <= 256'd0;
      hash_q     <= 256'd0;
      digest_q   <= 256'd0;
      run_cnt_q  <= 16'd0;
      tf_cnt_q   <= 6'd0;
      fb_q       <= 1'b0;
      final_q    <= 1'b0;
      pad2_q     <= 1'b0;
      pad2_80_q  <= 1'b0;
      lastidx_q  <= 4'd0;
      lastb_q    <= 2'd0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      s_ready_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      hstate_q   <= hstate_d;
      hash_q     <= hash_d;
      digest_q   <= digest_d;
      run_cnt_q  <= run_cnt_d;
      tf_cnt_q   <= tf_cnt_d;
      fb_q       <= fb_d;
      final_q    <= final_d;
      pad2_q     <= pad2_d;
      pad2_80_q  <= pad2_80_d;
      lastidx_q  <= lastidx_d;
      lastb_q    <= lastb_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s.s_ready    = s_ready_q;
  assign tf_feedback  = fb_q;
  assign tf_cnt       = tf_cnt_q;
  assign tf_state     = hstate_q;
  assign tf_input     = blk_q;
  assign digest       = digest_q;
  assign digest_valid = dv_q;
  assign busy         = busy_q;

endmodule

// File: doc/sha256_msg_ctrl.md
SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

Interface
REQ-001 Parameter LOOP, default 1: fold factor of the downstream sha256_transform; power of two, 1..64.
REQ-002 Parameter TF_LATENCY, default 68: clk cycles from block launch (tf_cnt=0, tf_feedback=0) to tf_hash valid.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_data  input  32  message word, big-endian; byte 0 in [31:24].
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  word is last of message.
REQ-008 s_bytes  input  2  valid bytes in last word (1,2,3; 0 means 4); ignored unless s_last.
REQ-009 s_ready  output  1  controller accepts a word this cycle.
REQ-010 tf_feedback  output  1  to transform feedback.
REQ-011 tf_cnt  output  6  to transform cnt.
REQ-012 tf_state  output  256  chaining value to transform rx_state; H0 in [255:224].
REQ-013 tf_input  output  512  padded block to transform rx_input; word 0 in [511:480].
REQ-014 tf_hash  input  256  transform result, already including the chaining add.
REQ-015 digest  output  256  final message hash, H0 in [255:224].
REQ-016 digest_valid  output  1  digest holds a completed result.
REQ-017 busy  output  1  high from first accepted word until digest_valid rises.

Function
REQ-018 A word transfers when s_valid and s_ready are both high on a rising clk edge.
REQ-019 States: IDLE, LOAD, PAD, RUN, NEXT; one state register, no other sequencing state.
REQ-020 IDLE: s_ready=1; first transfer stores word 0, clears digest_valid, sets busy, loads tf_state with the SHA-256 IV (6a09e667 ... 5be0cd19), goes LOAD (or PAD if s_last).
REQ-021 LOAD: s_ready=1; each transfer stores the next word, increments the word index; index wrap 15->0 with no s_last goes RUN with a full data block; s_last goes PAD.
REQ-022 Byte length counter: 61 bits, +4 per non-last word, +s_bytes (0 counts as 4) on the last word; bit length = byte count << 3, 64 bits.
REQ-023 PAD (one cycle per block, s_ready=0): 0x80 written to the byte after the last valid byte, remaining bytes of that word zeroed, later words zeroed; if the 0x80 byte is in words 0..13, words 14..15 get the big-endian bit length and the block is final.
REQ-024 If the 0x80 byte lands in word 14 or 15, or the last word fills word 15 completely, the current block is non-final; a second all-zero block carrying the length in words 14..15 (and 0x80 in word 0 byte 0 when word 15 was full) follows.
REQ-025 RUN: s_ready=0; tf_input and tf_state held stable for the entire run; tf_cnt counts 0..LOOP-1 repeatedly starting at 0 on the launch cycle; tf_feedback = (tf_cnt != 0).
REQ-026 RUN lasts exactly TF_LATENCY cycles; on the last cycle tf_hash is sampled.
REQ-027 NEXT: non-final block -> tf_state <= sampled tf_hash, go LOAD (data pending) or PAD (second padding block); final block -> digest <= tf_hash, digest_valid=1, busy=0, go IDLE.
REQ-028 digest and digest_valid held until the first word of the next message transfers.
REQ-029 A message whose data ends exactly at word 15 of a block runs that full data block, then one padding-only block.
REQ-030 s_valid while s_ready=0 is ignored; the upstream holds its word.
REQ-031 Messages are 1..2^61-1 bytes; empty messages are not supported.

Reset
REQ-032 reset_n low: state=IDLE, s_ready=1 once released, busy=0, digest_valid=0, digest=0, tf_cnt=0, tf_feedback=0, tf_state=0, tf_input=0, counters=0.
REQ-033 Reset asserted mid-message or mid-RUN aborts the message; the in-flight tf_hash is discarded.

Verification
REQ-034 "abc" (one word, s_bytes=3, s_last) -> one block, digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-035 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two blocks, digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-036 55-byte and 64-byte messages -> one and two RUN phases respectively, each RUN exactly TF_LATENCY cycles; tf_cnt sequence checked for LOOP=1 and LOOP=4.
REQ-037 Random s_valid gaps during LOAD and s_valid held high during RUN -> digests identical to the gap-free case; no word lost or duplicated.
REQ-038 reset_n pulsed mid-RUN, then "abc" sent -> correct "abc" digest; digest_valid low from reset until that result.
REQ-039 Back-to-back "abc" messages -> digest_valid drops on the second message's first transfer, rises again with the identical digest.
